// File: rtl/nnrv_mem_arb.sv
// -----------------------------------------------------------------------------
// nnrv_mem_arb
//
// Arbiter that shares one single-port RAM between the instruction fetch stage
// and the load/store unit. Grants are decided combinationally in the request
// cycle. Load/store normally wins. A starvation counter forces a fetch grant
// after STARVE_LIMIT consecutive fetch denials. Read responses come back one
// cycle after the grant. They are steered to the requester that owned the
// read.
//
// Parameters
//   XLEN          address / data width
//   STARVE_LIMIT  consecutive fetch denials that force a fetch grant (1..15)
//
// Ports
//   i_clk, i_rst                     clock, asynchronous active-high reset
//   i_if_req, i_if_addr              fetch read request and byte address
//   o_if_gnt, o_if_stall             fetch accepted / fetch present but denied
//   o_if_rvalid, o_if_rdata          fetch read response
//   i_ls_req, i_ls_we, i_ls_addr,
//   i_ls_wdata, i_ls_mask            load/store request
//   o_ls_gnt                         load/store accepted
//   o_ls_rvalid, o_ls_rdata          load response
//   o_ram_addr, o_ram_rd_en,
//   o_ram_wr_en, o_ram_mask,
//   o_ram_wdata, i_ram_rd_data       single-port RAM interface (1-cycle read)
//   o_conflict_cnt                   saturating count of both-request cycles
// -----------------------------------------------------------------------------
module nnrv_mem_arb #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,

  input  logic            i_if_req,
  input  logic [XLEN-1:0] i_if_addr,
  output logic            o_if_gnt,
  output logic            o_if_stall,
  output logic            o_if_rvalid,
  output logic [XLEN-1:0] o_if_rdata,

  input  logic            i_ls_req,
  input  logic            i_ls_we,
  input  logic [XLEN-1:0] i_ls_addr,
  input  logic [XLEN-1:0] i_ls_wdata,
  input  logic [3:0]      i_ls_mask,
  output logic            o_ls_gnt,
  output logic            o_ls_rvalid,
  output logic [XLEN-1:0] o_ls_rdata,

  output logic [XLEN-1:0] o_ram_addr,
  output logic            o_ram_rd_en,
  output logic            o_ram_wr_en,
  output logic [3:0]      o_ram_mask,
  output logic [XLEN-1:0] o_ram_wdata,
  input  logic [XLEN-1:0] i_ram_rd_data,

  output logic [15:0]     o_conflict_cnt
);

  localparam logic [3:0] LP_STARVE_LIMIT = 4'(STARVE_LIMIT);
  localparam logic       LP_OWNER_IF     = 1'b0;
  localparam logic       LP_OWNER_LS     = 1'b1;

  logic [3:0]  r_starve_cnt;
  logic        r_rsp_pending;
  logic        r_rsp_owner;
  logic [15:0] r_conflict_cnt;

  logic        w_force_if;
  logic        w_if_gnt;
  logic        w_ls_gnt;
  logic        w_rd_grant;

  // Grant decision: load/store wins unless fetch has been starved to the limit.
  always_comb begin
    w_if_gnt   = 1'b0;
    w_ls_gnt   = 1'b0;
    w_force_if = i_if_req & (r_starve_cnt == LP_STARVE_LIMIT);
    if (i_rst) begin
      // No grants may leak out while reset is held.
      w_if_gnt = 1'b0;
      w_ls_gnt = 1'b0;
    end else begin
      w_ls_gnt = i_ls_req & ~w_force_if;
      w_if_gnt = i_if_req & ~w_ls_gnt;
    end
  end

  // A read is outstanding after any fetch grant or any granted load.
  assign w_rd_grant = w_if_gnt | (w_ls_gnt & ~i_ls_we);

  // RAM port steering for the granted requester; idle port parks on fetch.
  always_comb begin
    o_ram_addr  = i_if_addr;
    o_ram_rd_en = 1'b0;
    o_ram_wr_en = 1'b0;
    o_ram_mask  = 4'b1111;
    o_ram_wdata = {XLEN{1'b0}};
    if (w_ls_gnt) begin
      o_ram_addr  = i_ls_addr;
      o_ram_rd_en = ~i_ls_we;
      o_ram_wr_en = i_ls_we;
      o_ram_mask  = i_ls_mask;
      o_ram_wdata = i_ls_wdata;
    end else if (w_if_gnt) begin
      o_ram_addr  = i_if_addr;
      o_ram_rd_en = 1'b1;
      o_ram_wr_en = 1'b0;
      o_ram_mask  = 4'b1111;
      o_ram_wdata = {XLEN{1'b0}};
    end else begin
      o_ram_addr  = i_if_addr;
      o_ram_rd_en = 1'b0;
      o_ram_wr_en = 1'b0;
      o_ram_mask  = 4'b1111;
      o_ram_wdata = {XLEN{1'b0}};
    end
  end

  // Starvation counter: counts consecutive fetch denials, saturating at the limit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_starve_cnt <= 4'd0;
    end else if (i_if_req & ~w_if_gnt) begin
      if (r_starve_cnt < LP_STARVE_LIMIT) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end else begin
        r_starve_cnt <= r_starve_cnt;
      end
    end else begin
      r_starve_cnt <= 4'd0;
    end
  end

  // Response tracking: remember whether a read was granted and who owns it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rsp_pending <= 1'b0;
      r_rsp_owner   <= LP_OWNER_IF;
    end else begin
      r_rsp_pending <= w_rd_grant;
      r_rsp_owner   <= w_ls_gnt ? LP_OWNER_LS : LP_OWNER_IF;
    end
  end

  // Conflict counter: cycles with both requesters active, saturating, never wraps.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_conflict_cnt <= 16'd0;
    end else if (i_if_req & i_ls_req & (r_conflict_cnt != 16'hFFFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end else begin
      r_conflict_cnt <= r_conflict_cnt;
    end
  end

  assign o_if_gnt       = w_if_gnt;
  assign o_ls_gnt       = w_ls_gnt;
  assign o_if_stall     = i_if_req & ~w_if_gnt & ~i_rst;
  assign o_if_rvalid    = r_rsp_pending & (r_rsp_owner == LP_OWNER_IF);
  assign o_ls_rvalid    = r_rsp_pending & (r_rsp_owner == LP_OWNER_LS);
  // Read data is a raw pass-through; consumers qualify it with rvalid.
  assign o_if_rdata     = i_ram_rd_data;
  assign o_ls_rdata     = i_ram_rd_data;
  assign o_conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_nnrv_mem_arb.sv
// Directed bench for nnrv_mem_arb with a behavioural RAM and a response scoreboard.
module tb_nnrv_mem_arb;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_if_req = 1'b0;
  logic [31:0] i_if_addr = 32'd0;
  logic        o_if_gnt, o_if_stall, o_if_rvalid;
  logic [31:0] o_if_rdata;
  logic        i_ls_req = 1'b0;
  logic        i_ls_we = 1'b0;
  logic [31:0] i_ls_addr = 32'd0;
  logic [31:0] i_ls_wdata = 32'd0;
  logic [3:0]  i_ls_mask = 4'hF;
  logic        o_ls_gnt, o_ls_rvalid;
  logic [31:0] o_ls_rdata;
  logic [31:0] o_ram_addr, o_ram_wdata;
  logic        o_ram_rd_en, o_ram_wr_en;
  logic [3:0]  o_ram_mask;
  logic [31:0] i_ram_rd_data = 32'd0;
  logic [15:0] o_conflict_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        v;
    logic        owner;   // 0 = fetch, 1 = load/store
    logic [31:0] data;
  } rsp_t;
  rsp_t sb[$];

  logic [31:0] mem  [256];  // RAM model driven by the DUT's RAM port
  logic [31:0] gold [256];  // bench's own expectation of RAM contents

  nnrv_mem_arb #(.XLEN(32), .STARVE_LIMIT(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr),
    .o_if_gnt(o_if_gnt), .o_if_stall(o_if_stall),
    .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_ls_req(i_ls_req), .i_ls_we(i_ls_we), .i_ls_addr(i_ls_addr),
    .i_ls_wdata(i_ls_wdata), .i_ls_mask(i_ls_mask),
    .o_ls_gnt(o_ls_gnt), .o_ls_rvalid(o_ls_rvalid), .o_ls_rdata(o_ls_rdata),
    .o_ram_addr(o_ram_addr), .o_ram_rd_en(o_ram_rd_en), .o_ram_wr_en(o_ram_wr_en),
    .o_ram_mask(o_ram_mask), .o_ram_wdata(o_ram_wdata), .i_ram_rd_data(i_ram_rd_data),
    .o_conflict_cnt(o_conflict_cnt)
  );

  always #5 i_clk = ~i_clk;

  // Single-port RAM with one-cycle read latency and byte-lane writes.
  always @(posedge i_clk) begin
    if (o_ram_wr_en) begin
      for (int b = 0; b < 4; b++)
        if (o_ram_mask[b]) mem[o_ram_addr[9:2]][8*b +: 8] <= o_ram_wdata[8*b +: 8];
    end
    if (o_ram_rd_en) i_ram_rd_data <= mem[o_ram_addr[9:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check grants/RAM port, check the response
  // due from the previous cycle, and push the response expected next cycle.
  task automatic cyc(input logic rst, input logic if_req, input logic [31:0] if_addr,
                     input logic ls_req, input logic ls_we, input logic [31:0] ls_addr,
                     input logic [31:0] ls_wdata, input logic [3:0] ls_mask,
                     input logic e_if, input logic e_ls);
    rsp_t r;
    @(negedge i_clk);
    i_rst = rst; i_if_req = if_req; i_if_addr = if_addr;
    i_ls_req = ls_req; i_ls_we = ls_we; i_ls_addr = ls_addr;
    i_ls_wdata = ls_wdata; i_ls_mask = ls_mask;
    #1;
    chk("if_gnt", {31'd0, o_if_gnt}, {31'd0, e_if});
    chk("ls_gnt", {31'd0, o_ls_gnt}, {31'd0, e_ls});
    chk("if_stall", {31'd0, o_if_stall}, {31'd0, ~rst & if_req & ~e_if});
    chk("ram_rd_en", {31'd0, o_ram_rd_en}, {31'd0, e_if | (e_ls & ~ls_we)});
    chk("ram_wr_en", {31'd0, o_ram_wr_en}, {31'd0, e_ls & ls_we});
    chk("ram_addr", o_ram_addr, e_ls ? ls_addr : if_addr);
    chk("ram_mask", {28'd0, o_ram_mask}, {28'd0, e_ls ? ls_mask : 4'b1111});
    if (!e_if) chk("ram_wdata", o_ram_wdata, e_ls ? ls_wdata : 32'd0);
    if (rst) sb.delete();
    r = (sb.size() > 0) ? sb.pop_front() : '0;
    chk("if_rvalid", {31'd0, o_if_rvalid}, {31'd0, r.v & ~r.owner});
    chk("ls_rvalid", {31'd0, o_ls_rvalid}, {31'd0, r.v & r.owner});
    if (r.v && !r.owner) chk("if_rdata", o_if_rdata, r.data);
    if (r.v && r.owner)  chk("ls_rdata", o_ls_rdata, r.data);
    if (e_ls && ls_we) begin
      for (int b = 0; b < 4; b++)
        if (ls_mask[b]) gold[ls_addr[9:2]][8*b +: 8] = ls_wdata[8*b +: 8];
    end
    if (rst)                sb.push_back('0);
    else if (e_if)          sb.push_back({1'b1, 1'b0, gold[if_addr[9:2]]});
    else if (e_ls && !ls_we) sb.push_back({1'b1, 1'b1, gold[ls_addr[9:2]]});
    else                    sb.push_back('0);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'h55C, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0, 1'b0);
  endtask

  task automatic both(input logic e_if, input logic e_ls);
    cyc(1'b0, 1'b1, 32'h20, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF, e_if, e_ls);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 32'hC0DE_0000 | (i << 2);
      gold[i] = 32'hC0DE_0000 | (i << 2);
    end

    // Reset held with both requests active: nothing granted, nothing counted.
    cyc(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 1'b0, 1'b0);
    chk("rst_conflict_cnt", {16'd0, o_conflict_cnt}, 32'd0);

    // Fetch-only stream starting in the first cycle out of reset.
    cyc(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF, 1'b1, 1'b0);
    idle();
    chk("conflict_cnt_0", {16'd0, o_conflict_cnt}, 32'd0);

    // Both held: load/store wins four times, then fetch is forced.
    repeat (4) both(1'b0, 1'b1);
    both(1'b1, 1'b0);
    idle();
    chk("conflict_cnt_5", {16'd0, o_conflict_cnt}, 32'd5);

    // Dropping the fetch request clears the starvation count.
    repeat (2) both(1'b0, 1'b1);
    cyc(1'b0, 1'b0, 32'h20, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 1'b0, 1'b1);
    repeat (4) both(1'b0, 1'b1);
    both(1'b1, 1'b0);
    idle();
    chk("conflict_cnt_12", {16'd0, o_conflict_cnt}, 32'd12);

    // Masked store, then load back the merged word.
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 4'b0011, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0, 1'b1);
    idle();
    chk("store_merge_gold", gold[16], 32'hC0DE_BEEF);

    // Alternating owners on consecutive cycles.
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0, 4'hF, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 32'hC, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h88, 32'h0, 4'b0101, 1'b0, 1'b1);
    idle();

    // Reset right after a granted load discards its response.
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h84, 32'h0, 4'hF, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0, 1'b0);
    chk("midrst_conflict_cnt", {16'd0, o_conflict_cnt}, 32'd0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0, 1'b0);
    idle();
    idle();
    both(1'b0, 1'b1);
    idle();

    // Long conflict: counter saturates and stays saturated.
    @(negedge i_clk);
    i_if_req = 1'b1; i_ls_req = 1'b1; i_ls_we = 1'b0;
    i_if_addr = 32'h20; i_ls_addr = 32'h100;
    repeat (70000) @(posedge i_clk);
    @(negedge i_clk); #1;
    chk("conflict_sat", {16'd0, o_conflict_cnt}, 32'h0000_FFFF);
    repeat (5) @(posedge i_clk);
    @(negedge i_clk); #1;
    chk("conflict_sat_hold", {16'd0, o_conflict_cnt}, 32'h0000_FFFF);
    i_if_req = 1'b0; i_ls_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nnrv_mem_arb.md
NNRV_MEM_ARB -- requirements
Module: nnrv_mem_arb

Interface
REQ-001 Parameter XLEN, default 32: address and data width.
REQ-002 Parameter STARVE_LIMIT, default 4: consecutive fetch denials that force a fetch grant; legal range 1..15.
REQ-003 i_clk  in  1  clock; all state changes on its rising edge.
REQ-004 i_rst  in  1  reset, asynchronous, active-high.
REQ-005 i_if_req  in  1  fetch read request, from the instruction fetch stage.
REQ-006 i_if_addr  in  XLEN  fetch byte address.
REQ-007 o_if_gnt  out  1  fetch request accepted this cycle.
REQ-008 o_if_stall  out  1  fetch request present but denied this cycle.
REQ-009 o_if_rvalid  out  1  o_if_rdata valid this cycle.
REQ-010 o_if_rdata  out  XLEN  fetch read data.
REQ-011 i_ls_req  in  1  load/store request.
REQ-012 i_ls_we  in  1  1 = store, 0 = load.
REQ-013 i_ls_addr  in  XLEN  load/store byte address.
REQ-014 i_ls_wdata  in  XLEN  store data.
REQ-015 i_ls_mask  in  4  byte-lane enables.
REQ-016 o_ls_gnt  out  1  load/store accepted this cycle.
REQ-017 o_ls_rvalid  out  1  o_ls_rdata valid this cycle.
REQ-018 o_ls_rdata  out  XLEN  load data.
REQ-019 o_ram_addr  out  XLEN  address to the single-port RAM.
REQ-020 o_ram_rd_en / o_ram_wr_en  out  1 each  RAM read / write strobes.
REQ-021 o_ram_mask  out  4  RAM byte mask.
REQ-022 o_ram_wdata  out  XLEN  RAM write data.
REQ-023 i_ram_rd_data  in  XLEN  RAM read data, valid one cycle after o_ram_rd_en.
REQ-024 o_conflict_cnt  out  16  count of cycles where both requesters were active.

Function
REQ-025 Grant decision: combinational, same cycle as the request; at most one grant per cycle.
REQ-026 Default priority: load/store wins over fetch.
REQ-027 Starvation counter: 4-bit, called starve_cnt.
  - Increments (saturating at STARVE_LIMIT) each cycle fetch is denied.
  - Clears to 0 when fetch is granted or i_if_req=0.
REQ-028 When starve_cnt==STARVE_LIMIT and i_if_req=1: fetch is granted and load/store is denied for that cycle.
REQ-029 o_if_stall = i_if_req & ~o_if_gnt.
REQ-030 RAM port, fetch granted: o_ram_addr=i_if_addr, rd_en=1, wr_en=0, mask=4'b1111.
REQ-031 RAM port, load/store granted:
  - o_ram_addr=i_ls_addr, o_ram_mask=i_ls_mask, o_ram_wdata=i_ls_wdata.
  - wr_en=i_ls_we, rd_en=~i_ls_we.
REQ-032 RAM port, no grant: rd_en=0, wr_en=0, addr=i_if_addr, mask=4'b1111, wdata=0.
REQ-033 Response tracking: registered rsp_pending and rsp_owner record a granted read (not a write) at each edge.
REQ-034 Read response: exactly one cycle after a granted read, the owner's rvalid is 1.
  - The owner's rdata = i_ram_rd_data.
  - The other rvalid is 0.
REQ-035 Stores produce no rvalid.
REQ-036 Back-to-back reads from alternating owners each get their own response on consecutive cycles; no response is dropped or duplicated.
REQ-037 o_if_rdata and o_ls_rdata pass i_ram_rd_data through unconditionally; consumers qualify them with rvalid.
REQ-038 o_conflict_cnt increments when i_if_req & i_ls_req, saturates at 16'hFFFF, and never wraps.
REQ-039 Requests are not required to hold after denial; the arbiter keeps no request queue.

Reset
REQ-040 While i_rst=1:
  - o_if_gnt, o_ls_gnt, o_if_stall, o_ram_rd_en and o_ram_wr_en are all 0.
  - starve_cnt, rsp_pending, rsp_owner and o_conflict_cnt are 0.
  - Both rvalid outputs are 0.
REQ-041 Reset asserted mid-read discards the pending response; no rvalid appears after reset deassertion.
REQ-042 First grant possible in the first cycle with i_rst=0.

Verification
REQ-043 Fetch only, i_if_req=1, addr 0x0,0x4,0x8 -> o_if_gnt=1 each cycle; o_if_rvalid=1 one cycle later with the RAM word at each address; o_if_stall=0.
REQ-044 i_if_req=1 and i_ls_req=1 (load 0x100) held, STARVE_LIMIT=4 -> ls granted for 4 cycles with o_if_stall=1; 5th cycle if granted; starve_cnt returns to 0; o_conflict_cnt=5.
REQ-045 Store 0xDEADBEEF, mask 4'b0011, to 0x40, then load 0x40 -> wr_en pulse with mask 0011 and no rvalid for the store; the load returns the lower halfword updated.
REQ-046 Alternating grants: ls load, then if fetch, on consecutive cycles -> o_ls_rvalid then o_if_rvalid on consecutive cycles, each with the correct data.
REQ-047 i_rst asserted the cycle after a granted load -> o_ls_rvalid stays 0 through and after reset; all counters read 0.
REQ-048 Both requests held for 70000 cycles -> o_conflict_cnt=16'hFFFF and holds there.
